// File: rtl/sample_to_pixel_raster_pkg.sv
// Shared constants and FSM state type for the scrolling scope-trace renderer.
package sample_to_pixel_raster_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam int DATA_WIDTH    = 32;
    localparam int SAMPLE_WIDTH  = 24;
    localparam int AMP_WIDTH     = 9;
    localparam int Y_CENTER      = 240;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CALC,
        DRAW
    } state_t;

endpackage

// File: rtl/framebuffer.sv
// 1-bit framebuffer: write port on wrclk, registered read port (old data on same-address collision).
module framebuffer #(
    parameter int DEPTH      = 640 * 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  wrclk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data
);

    // Contents are loaded blank at configuration; resetn never touches the array.
    logic ram [DEPTH] = '{default: 1'b0};

    always_ff @(posedge wrclk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge wrclk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= 1'b0;
        end else begin
            rd_data <= ram[rd_addr];
        end
    end

endmodule

// File: rtl/sample_to_pixel.sv
// Pops one sample per column and rewrites that column: clear plus a segment from prev_y to y.
//   state | meaning
//   IDLE  | wait for a sample at the FIFO head
//   READ  | pop strobe high; sample latched at the closing edge
//   CALC  | y / lo / hi settle from the latched amplitude
//   DRAW  | one pixel write per row, top to bottom
module sample_to_pixel #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_WIDTH    = 19,
    parameter int DATA_WIDTH    = 32,
    parameter int SAMPLE_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] mono_sample,
    input  logic                  fifo_almost_empty,
    output logic                  fifo_rd_en,
    output logic [ADDR_WIDTH-1:0] pixel_addr,
    output logic                  pixel_data,
    output logic                  pixel_wr_en
);
    import sample_to_pixel_raster_pkg::*;

    localparam int COL_W = $clog2(SCREEN_WIDTH);
    localparam int ROW_W = $clog2(SCREEN_HEIGHT);
    localparam int Y_W   = ROW_W + 2;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCREEN_HEIGHT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_WIDTH - 1);

    state_t                        r_state, w_next_state;
    logic signed [AMP_WIDTH-1:0]   r_amp;
    logic [COL_W-1:0]              r_x;
    logic [ROW_W-1:0]              r_prev_y, r_row;
    logic [ROW_W-1:0]              w_y, w_seg_start, w_lo, w_hi, w_next_row;
    logic signed [Y_W-1:0]         w_y_raw;
    logic [ADDR_WIDTH-1:0]         r_pixel_addr, w_next_addr;
    logic                          r_fifo_rd_en, r_pixel_wr_en, r_pixel_data;
    logic                          w_drawing;
    logic                          w_unused_bits;

    assign w_unused_bits = ^{mono_sample[DATA_WIDTH-1:SAMPLE_WIDTH],
                             mono_sample[SAMPLE_WIDTH-AMP_WIDTH-1:0]};

    assign w_y_raw = Y_W'(Y_CENTER) - Y_W'(r_amp);

    always_comb begin
        if (w_y_raw[Y_W-1]) begin
            w_y = '0;
        end else if (w_y_raw > Y_W'(SCREEN_HEIGHT - 1)) begin
            w_y = LAST_ROW;
        end else begin
            w_y = w_y_raw[ROW_W-1:0];
        end
    end

    // Column 0 has no left neighbour on screen, so its segment collapses to one pixel.
    assign w_seg_start = (r_x == '0) ? w_y : r_prev_y;
    assign w_lo        = (w_seg_start < w_y) ? w_seg_start : w_y;
    assign w_hi        = (w_seg_start < w_y) ? w_y : w_seg_start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (!fifo_almost_empty) w_next_state = READ;
            READ: w_next_state = CALC;
            CALC: w_next_state = DRAW;
            DRAW: if (r_row == LAST_ROW) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_drawing   = (w_next_state == DRAW);
    assign w_next_row  = (r_state == CALC) ? '0 : r_row + 1'b1;
    assign w_next_addr = (r_state == CALC) ? ADDR_WIDTH'(r_x)
                                           : r_pixel_addr + ADDR_WIDTH'(SCREEN_WIDTH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fifo_rd_en  <= 1'b0;
            r_pixel_wr_en <= 1'b0;
            r_pixel_data  <= 1'b0;
            r_pixel_addr  <= '0;
            r_row         <= '0;
            r_amp         <= '0;
            r_x           <= '0;
            r_prev_y      <= ROW_W'(Y_CENTER);
        end else begin
            r_fifo_rd_en  <= (w_next_state == READ);
            r_pixel_wr_en <= w_drawing;
            r_pixel_addr  <= w_drawing ? w_next_addr : '0;
            r_pixel_data  <= w_drawing && (w_next_row >= w_lo) && (w_next_row <= w_hi);
            if (w_drawing) begin
                r_row <= w_next_row;
            end
            if (r_state == READ) begin
                r_amp <= mono_sample[SAMPLE_WIDTH-1 -: AMP_WIDTH];
            end
            if (r_state == DRAW && w_next_state == IDLE) begin
                r_x      <= (r_x == LAST_COL) ? '0 : r_x + 1'b1;
                r_prev_y <= w_y;
            end
        end
    end

    assign fifo_rd_en  = r_fifo_rd_en;
    assign pixel_wr_en = r_pixel_wr_en;
    assign pixel_data  = r_pixel_data;
    assign pixel_addr  = r_pixel_addr;

endmodule

// File: rtl/sample_to_pixel_raster.sv
// Audio-scope renderer: sample-to-column drawing engine feeding a 1-bit framebuffer.
module sample_to_pixel_raster #(
    parameter int SCREEN_WIDTH  = sample_to_pixel_raster_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = sample_to_pixel_raster_pkg::SCREEN_HEIGHT,
    parameter int ADDR_WIDTH    = sample_to_pixel_raster_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH    = sample_to_pixel_raster_pkg::DATA_WIDTH,
    parameter int SAMPLE_WIDTH  = sample_to_pixel_raster_pkg::SAMPLE_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] mono_sample,
    input  logic                  fifo_almost_empty,
    output logic                  fifo_rd_en,
    output logic [ADDR_WIDTH-1:0] pixel_addr,
    output logic                  pixel_data,
    output logic                  pixel_wr_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data
);

    sample_to_pixel #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .SAMPLE_WIDTH  (SAMPLE_WIDTH)
    ) u_draw (
        .clk               (clk),
        .resetn            (resetn),
        .mono_sample       (mono_sample),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_en        (fifo_rd_en),
        .pixel_addr        (pixel_addr),
        .pixel_data        (pixel_data),
        .pixel_wr_en       (pixel_wr_en)
    );

    framebuffer #(
        .DEPTH      (SCREEN_WIDTH * SCREEN_HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fb (
        .wrclk   (clk),
        .resetn  (resetn),
        .wr_en   (pixel_wr_en),
        .wr_addr (pixel_addr),
        .wr_data (pixel_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_sample_to_pixel_raster.sv
// Scope-trace renderer bench: narrow screen so column wrap fits a short run; model is a pixel-array trace.
module tb_sample_to_pixel_raster;

    localparam int W  = 16;
    localparam int H  = 480;
    localparam int AW = $clog2(W * H);

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   mono_sample = '0;
    logic          fifo_almost_empty = 1'b1;
    logic          fifo_rd_en, pixel_data, pixel_wr_en, rd_data;
    logic [AW-1:0] pixel_addr;
    logic [AW-1:0] rd_addr = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int addr;
        bit data;
    } wr_t;

    wr_t exp_q[$];
    bit  fb_model [W*H];
    int  m_x = 0;
    int  m_prev = 240;
    int  rd_pulses = 0;
    int  wr_count = 0;
    int  rd0 = 0;
    int  wr0 = 0;

    always #5 clk = ~clk;

    sample_to_pixel_raster #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (32),
        .SAMPLE_WIDTH  (24)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mono_sample       (mono_sample),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_en        (fifo_rd_en),
        .pixel_addr        (pixel_addr),
        .pixel_data        (pixel_data),
        .pixel_wr_en       (pixel_wr_en),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int map_y(input logic [31:0] v);
        int s;
        int y;
        s = int'(v[23:15]);
        if (s > 255) s = s - 512;
        y = 240 - s;
        if (y < 0) y = 0;
        if (y > H - 1) y = H - 1;
        return y;
    endfunction

    task automatic model_column(input logic [31:0] v);
        int y, p, lo, hi;
        y  = map_y(v);
        p  = (m_x == 0) ? y : m_prev;
        lo = (p < y) ? p : y;
        hi = (p < y) ? y : p;
        for (int r = 0; r < H; r++) begin
            exp_q.push_back('{addr: r * W + m_x, data: (r >= lo && r <= hi)});
        end
        m_x    = (m_x + 1) % W;
        m_prev = y;
    endtask

    // Write scoreboard: every framebuffer write must match the next predicted one.
    always @(negedge clk) begin
        wr_t e;
        if (resetn) begin
            if (fifo_rd_en) rd_pulses++;
            if (pixel_wr_en) begin
                wr_count++;
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(pixel_addr), 32'(e.addr));
                    check("wr_data", 32'(pixel_data), 32'(e.data));
                    fb_model[e.addr] = e.data;
                end
            end
        end
    end

    task automatic feed_start(input logic [31:0] v);
        int seen;
        model_column(v);
        rd0 = rd_pulses;
        wr0 = wr_count;
        @(negedge clk);
        mono_sample       = v;
        fifo_almost_empty = 1'b0;
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) seen = 1;
        end
        check("rd_en_seen", 32'(seen), 32'd1);
        @(negedge clk);
        fifo_almost_empty = 1'b1;
        mono_sample       = $urandom();
        check("rd_en_one_cycle", 32'(fifo_rd_en), 32'd0);
        check("no_write_in_calc", 32'(pixel_wr_en), 32'd0);
        @(negedge clk);
        check("first_write_latency", 32'(pixel_wr_en), 32'd1);
    endtask

    task automatic wait_done();
        int done;
        done = 0;
        for (int i = 0; i < 600 && done == 0; i++) begin
            @(negedge clk);
            if (pixel_wr_en !== 1'b1) done = 1;
        end
        check("draw_finished", 32'(done), 32'd1);
        check("rd_pulses_per_sample", 32'(rd_pulses - rd0), 32'd1);
        check("writes_per_sample", 32'(wr_count - wr0), 32'(H));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic feed(input logic [31:0] v);
        feed_start(v);
        wait_done();
    endtask

    task automatic px(input string tag, input int a, input bit expv);
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(expv));
    endtask

    task automatic readback(input string tag);
        @(negedge clk);
        rd_addr = '0;
        for (int a = 0; a < W * H; a++) begin
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, a), 32'(rd_data), 32'(fb_model[a]));
            if (a + 1 < W * H) rd_addr = AW'(a + 1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},   32'(fifo_rd_en),  32'd0);
        check({tag, "_wr_en"},   32'(pixel_wr_en), 32'd0);
        check({tag, "_data"},    32'(pixel_data),  32'd0);
        check({tag, "_addr"},    32'(pixel_addr),  32'd0);
        check({tag, "_rd_data"}, 32'(rd_data),     32'd0);
    endtask

    initial begin
        int found;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        resetn = 1'b1;

        rd0 = rd_pulses;
        wr0 = wr_count;
        repeat (1000) @(negedge clk);
        check("idle_no_rd_en", 32'(rd_pulses - rd0), 32'd0);
        check("idle_no_wr_en", 32'(wr_count - wr0), 32'd0);

        feed(32'h0000_0000);
        feed(32'h0032_0000);
        feed(32'h007F_FFFF);
        feed(32'hFF80_0000);

        px("c0_r240", 240 * W + 0, 1'b1);
        px("c0_r239", 239 * W + 0, 1'b0);
        px("c0_r241", 241 * W + 0, 1'b0);
        px("c1_r139", 139 * W + 1, 1'b0);
        px("c1_r140", 140 * W + 1, 1'b1);
        px("c1_r240", 240 * W + 1, 1'b1);
        px("c1_r241", 241 * W + 1, 1'b0);
        px("c2_r0",   0 * W + 2,   1'b1);
        px("c2_r141", 141 * W + 2, 1'b0);
        px("c3_r0",   0 * W + 3,   1'b1);
        px("c3_r479", 479 * W + 3, 1'b1);

        for (int k = 4; k < W; k++) begin
            feed($urandom());
        end

        // Wrap to column 0; read the pixel being overwritten in the same cycle.
        feed_start(32'h007F_FFFF);
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            if (pixel_wr_en === 1'b1 && pixel_addr === AW'(240 * W)) found = 1;
            else @(negedge clk);
        end
        check("rdw_addr_reached", 32'(found), 32'd1);
        rd_addr = AW'(240 * W);
        @(negedge clk);
        check("rdw_old_value", 32'(rd_data), 32'd1);
        @(negedge clk);
        check("rdw_new_value", 32'(rd_data), 32'd0);
        wait_done();

        readback("fb_after_wrap");
        px("wrap_c0_r0",   0,       1'b1);
        px("wrap_c0_r240", 240 * W, 1'b0);

        // Abort a column roughly 100 rows in.
        feed_start($urandom());
        repeat (97) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1 check_outputs_zero("async_reset");
        exp_q.delete();
        m_x    = 0;
        m_prev = 240;
        repeat (3) @(negedge clk);
        check_outputs_zero("held_reset");
        resetn = 1'b1;

        rd0 = rd_pulses;
        wr0 = wr_count;
        repeat (5) @(negedge clk);
        check("post_reset_idle_rd", 32'(rd_pulses - rd0), 32'd0);
        check("post_reset_idle_wr", 32'(wr_count - wr0), 32'd0);

        feed(32'h0032_0000);
        px("post_reset_c0_r140", 140 * W, 1'b1);
        px("post_reset_c0_r0",   0,       1'b0);
        readback("fb_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
